// File: rtl/mult_pkg.sv
// Shared constants and types for the shift-and-add multiplier controller.
package mult_pkg;

  // Operand width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. dbg_state_o exposes this encoding directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple adder is built by chaining these.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with carry-in tied to zero. This is the
// single adder that the multiplier reuses on every iteration.
module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;
  assign cout_o   = carry[WIDTH];

  // Carry ripples from bit 0 upward through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one shared WIDTH-bit adder,
// WIDTH iterations per product, start/ready/done handshake.
//
// Handshake: start is sampled only on a rising edge where ready=1 (states
// IDLE and DONE); a and b are captured on that same edge. While busy=1 start
// is ignored. done is a one-cycle pulse in the cycle product becomes valid,
// and product then holds until the next accepted start completes. ready,
// busy and done decode the registered state only, so start never reaches
// them combinationally.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             dbg_state_o
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // The accumulator is conceptually 2W+1 bits (carry, upper half, multiplier
  // bits). After every right shift the top bit is zero, so only the lower
  // 2W bits are stored; the carry lives only inside one iteration.
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] acc_shift;

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    addend = acc_q[0] ? mcand_q : '0;
  end

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (acc_q[2*WIDTH-1:WIDTH]),
    .b_i    (addend),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // New upper half {carry, sum} replaces the old one, then everything moves
  // right by one; the consumed multiplier bit drops off the bottom.
  always_comb begin
    acc_shift = {add_cout, add_sum, acc_q[WIDTH-1:1]};
  end

  // State, datapath and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath control; DONE accepts start directly so
  // back-to-back operations need no IDLE cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = acc_shift;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are plain decodes of the registered state.
  always_comb begin
    ready       = (state_q == IDLE) || (state_q == DONE);
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    product     = product_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: three instances (WIDTH 2, 8, 16). Drivers
// push a*b into expected queues; negedge monitors pop on every done pulse.
module tb_shift_add_mult_ctrl;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start2 = 1'b0, start8 = 1'b0, start16 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready2, busy2, done2, ready8, busy8, done8, ready16, busy16, done16;
  logic [3:0]  product2;
  logic [15:0] product8;
  logic [31:0] product16;
  state_t      st2, st8, st16;

  shift_add_mult_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .busy(busy2), .done(done2), .product(product2), .dbg_state_o(st2));
  shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8), .dbg_state_o(st8));
  shift_add_mult_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16), .dbg_state_o(st16));

  // ---------------- scoreboard state ----------------
  logic [31:0] exp2_q[$], exp8_q[$], exp16_q[$];
  int          acc2_q[$], acc8_q[$], acc16_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Record the cycle of every accepted start (for latency checking).
  always @(posedge clk) begin
    if (!rst && start2  && ready2)  acc2_q.push_back(cyc);
    if (!rst && start8  && ready8)  acc8_q.push_back(cyc);
    if (!rst && start16 && ready16) acc16_q.push_back(cyc);
  end

  // ---------------- monitors ----------------
  logic        pd2 = 1'b0, pd8 = 1'b0, pd16 = 1'b0;
  logic [3:0]  pp2 = '0;
  logic [15:0] pp8 = '0;
  logic [31:0] pp16 = '0;

  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_rdy_bsy2", {31'b0, ready2 ^ busy2}, 32'd1);
      if (done2) begin
        if (pd2) fail("done_width2");
        if (exp2_q.size() == 0) fail("done_unexpected2");
        else check("product2", product2, exp2_q.pop_front());
        if (acc2_q.size() == 0) fail("latency_noacc2");
        else check("latency2", cyc - acc2_q.pop_front(), 32'd3);
      end else if (product2 !== pp2) check("product_hold2", product2, pp2);
    end
    pd2 <= done2;
    pp2 <= product2;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_rdy_bsy8", {31'b0, ready8 ^ busy8}, 32'd1);
      if (done8) begin
        if (pd8) fail("done_width8");
        if (exp8_q.size() == 0) fail("done_unexpected8");
        else check("product8", product8, exp8_q.pop_front());
        if (acc8_q.size() == 0) fail("latency_noacc8");
        else check("latency8", cyc - acc8_q.pop_front(), 32'd9);
      end else if (product8 !== pp8) check("product_hold8", product8, pp8);
    end
    pd8 <= done8;
    pp8 <= product8;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_rdy_bsy16", {31'b0, ready16 ^ busy16}, 32'd1);
      if (done16) begin
        if (pd16) fail("done_width16");
        if (exp16_q.size() == 0) fail("done_unexpected16");
        else check("product16", product16, exp16_q.pop_front());
        if (acc16_q.size() == 0) fail("latency_noacc16");
        else check("latency16", cyc - acc16_q.pop_front(), 32'd17);
      end else if (product16 !== pp16) check("product_hold16", product16, pp16);
    end
    pd16 <= done16;
    pp16 <= product16;
  end

  // ---------------- driver tasks (WIDTH=8) ----------------
  task automatic wait_ready8();
    for (int t = 0; t < 100 && !ready8; t++) @(negedge clk);
    if (!ready8) fail("ready_timeout8");
  endtask

  task automatic drain8();
    for (int t = 0; t < 100 && exp8_q.size() != 0; t++) @(negedge clk);
    check("drain8", exp8_q.size(), 32'd0);
  endtask

  // Issue one operation; optionally confirm ready stays low through RUN.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit chk);
    wait_ready8();
    start8 = 1'b1; a8 = av; b8 = bv;
    exp8_q.push_back(32'(av) * 32'(bv));
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    if (chk) begin
      for (int i = 0; i < 8; i++) begin
        check("ready_low_run8", {31'b0, ready8}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    fail("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_product8", product8, 32'd0);
    check("reset_ready8", {31'b0, ready8}, 32'd1);
    check("reset_busy8", {31'b0, busy8}, 32'd0);
    check("reset_done8", {31'b0, done8}, 32'd0);
    check("reset_state8", 32'(st8), 32'(IDLE));
    check("reset_product2", product2, 32'd0);
    check("reset_product16", product16, 32'd0);

    // Directed operand patterns.
    op8(8'h0F, 8'h0F, 1'b1);
    check("done_after_run8", {31'b0, done8}, 32'd1);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h00, 8'hA5, 1'b0);
    op8(8'h01, 8'h80, 1'b0);
    drain8();

    // start pulses while busy must be ignored.
    wait_ready8();
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    exp8_q.push_back(32'd15);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk); start8 = 1'b0;
    drain8();

    // Back-to-back with start held high; second operands applied in DONE.
    wait_ready8();
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
    exp8_q.push_back(32'd6);
    @(negedge clk);
    for (int t = 0; t < 50 && !done8; t++) @(negedge clk);
    if (!done8) fail("b2b_done_timeout8");
    a8 = 8'd7; b8 = 8'd9;
    exp8_q.push_back(32'd63);
    @(negedge clk);
    check("b2b_no_idle8", {31'b0, busy8}, 32'd1);
    start8 = 1'b0;
    drain8();

    // Asynchronous reset in the middle of RUN.
    wait_ready8();
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    exp8_q.push_back(32'h33 * 32'h44);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy8", {31'b0, busy8}, 32'd1);
    #2 rst = 1'b1;
    exp8_q.delete();
    acc8_q.delete();
    #1;
    check("async_rst_product8", product8, 32'd0);
    check("async_rst_ready8", {31'b0, ready8}, 32'd1);
    check("async_rst_busy8", {31'b0, busy8}, 32'd0);
    check("async_rst_done8", {31'b0, done8}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    op8(8'h10, 8'h10, 1'b0);
    drain8();

    // Randomised streams on all three widths in parallel.
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [1:0] ra, rb;
          ra = (n == 0) ? 2'd3 : 2'($urandom_range(0, 3));
          rb = (n == 0) ? 2'd3 : 2'($urandom_range(0, 3));
          for (int t = 0; t < 100 && !ready2; t++) @(negedge clk);
          if (!ready2) fail("ready_timeout2");
          start2 = 1'b1; a2 = ra; b2 = rb;
          exp2_q.push_back(32'(ra) * 32'(rb));
          @(negedge clk);
          start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [7:0] ra, rb;
          ra = 8'($urandom);
          rb = 8'($urandom);
          op8(ra, rb, 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            if (!busy8) begin
              start8 = 1'b0;
              fail("busy_after_start8");
            end
            start8 = 1'b0;
          end
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [15:0] ra, rb;
          ra = (n == 0) ? 16'hFFFF : 16'($urandom);
          rb = (n == 0) ? 16'hFFFF : 16'($urandom);
          for (int t = 0; t < 100 && !ready16; t++) @(negedge clk);
          if (!ready16) fail("ready_timeout16");
          start16 = 1'b1; a16 = ra; b16 = rb;
          exp16_q.push_back(32'(ra) * 32'(rb));
          @(negedge clk);
          start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    for (int t = 0; t < 200 && (exp2_q.size() + exp8_q.size() + exp16_q.size()) != 0; t++)
      @(negedge clk);
    check("final_drain2", exp2_q.size(), 32'd0);
    check("final_drain8", exp8_q.size(), 32'd0);
    check("final_drain16", exp16_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
